// File: rtl/mem_io_responder.sv
// Byte-wide RAM + memory-mapped TX/RX FIFO responder on the CPU memory-controller bus.
// Optional status register at 0x30004 is built only when MEM_IO_STATUS_EN is defined.
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        r_or_w,
  input  logic [31:0] a_in,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALMOST_C  = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE_C = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO_C = CW'(0);
  localparam logic [PW-1:0] PTR_ONE_C = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO_C = PW'(0);

  logic [7:0]            mem_r [0:(1<<ADDR_WIDTH)-1];
  logic [7:0]            tx_mem_r [FIFO_DEPTH];
  logic [7:0]            rx_mem_r [FIFO_DEPTH];
  logic [PW-1:0]         tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
  logic [CW-1:0]         tx_count_r, rx_count_r;
  logic [7:0]            d_out_r;

  logic                  io_sel_s, data_reg_s, stat_reg_s, ram_we_s;
  logic                  tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic                  tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic [ADDR_WIDTH-1:0] ram_addr_s;
  logic [7:0]            ram_q_s, rx_head_s, status_s, rd_next_s;
  logic                  unused_s;

  assign ram_addr_s = a_in[ADDR_WIDTH-1:0];
  assign ram_q_s    = mem_r[ram_addr_s];
  assign rx_head_s  = rx_mem_r[rx_rd_ptr_r];
  assign unused_s   = ^a_in[31:18];

  // Address decode and FIFO handshake qualification.
  always_comb begin
    io_sel_s   = (a_in[17:16] == 2'b11);
    data_reg_s = io_sel_s && (a_in[15:0] == 16'h0000);
    stat_reg_s = io_sel_s && (a_in[15:0] == 16'h0004);
    ram_we_s   = rdy && r_or_w && !io_sel_s;
    tx_full_s  = (tx_count_r == DEPTH_C);
    tx_empty_s = (tx_count_r == CNT_ZERO_C);
    rx_full_s  = (rx_count_r == DEPTH_C);
    rx_empty_s = (rx_count_r == CNT_ZERO_C);
    tx_pop_s   = !tx_empty_s && tx_ready;
    tx_push_s  = rdy && r_or_w && data_reg_s && (!tx_full_s || tx_pop_s);
    rx_pop_s   = rdy && !r_or_w && data_reg_s && !rx_empty_s;
    // A full RX FIFO still accepts a host byte in the cycle the CPU frees a slot.
    rx_push_s  = rx_valid && (!rx_full_s || rx_pop_s);
  end

`ifdef MEM_IO_STATUS_EN
  assign status_s = {6'b000000, !rx_empty_s, tx_full_s};
`else
  assign status_s = 8'h00;
`endif

  // Next read-data selection; holds when the CPU side is idle or writing.
  always_comb begin
    rd_next_s = d_out_r;
    if (rdy && !r_or_w) begin
      if (!io_sel_s) begin
        rd_next_s = ram_q_s;
      end else if (data_reg_s) begin
        rd_next_s = rx_empty_s ? 8'h00 : rx_head_s;
      end else if (stat_reg_s) begin
        rd_next_s = status_s;
      end else begin
        rd_next_s = 8'h00;
      end
    end else begin
      rd_next_s = d_out_r;
    end
  end

  // RAM array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[ram_addr_s] <= d_in;
    end
  end

  // Read data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out_r <= 8'h00;
    end else begin
      d_out_r <= rd_next_s;
    end
  end

  // TX FIFO: CPU pushes, host pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem_r[i] <= 8'h00;
      tx_wr_ptr_r <= PTR_ZERO_C;
      tx_rd_ptr_r <= PTR_ZERO_C;
      tx_count_r  <= CNT_ZERO_C;
    end else begin
      if (tx_push_s) begin
        tx_mem_r[tx_wr_ptr_r] <= d_in;
        tx_wr_ptr_r           <= tx_wr_ptr_r + PTR_ONE_C;
      end
      if (tx_pop_s) begin
        tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE_C;
      end
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_count_r <= tx_count_r + CNT_ONE_C;
        2'b01:   tx_count_r <= tx_count_r - CNT_ONE_C;
        default: tx_count_r <= tx_count_r;
      endcase
    end
  end

  // RX FIFO: host pushes, CPU pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem_r[i] <= 8'h00;
      rx_wr_ptr_r <= PTR_ZERO_C;
      rx_rd_ptr_r <= PTR_ZERO_C;
      rx_count_r  <= CNT_ZERO_C;
    end else begin
      if (rx_push_s) begin
        rx_mem_r[rx_wr_ptr_r] <= rx_data;
        rx_wr_ptr_r           <= rx_wr_ptr_r + PTR_ONE_C;
      end
      if (rx_pop_s) begin
        rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE_C;
      end
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_count_r <= rx_count_r + CNT_ONE_C;
        2'b01:   rx_count_r <= rx_count_r - CNT_ONE_C;
        default: rx_count_r <= rx_count_r;
      endcase
    end
  end

  assign d_out          = d_out_r;
  assign tx_valid       = !tx_empty_s;
  assign tx_data        = tx_mem_r[tx_rd_ptr_r];
  assign rx_ready       = !rx_full_s || rx_pop_s;
  assign io_buffer_full = (tx_count_r >= ALMOST_C);

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder (default parameters).
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst, rdy, r_or_w, tx_ready, rx_valid;
  logic [31:0] a_in;
  logic [7:0]  d_in, rx_data;
  logic [7:0]  d_out, tx_data;
  logic        io_buffer_full, tx_valid, rx_ready;

  int total_cnt = 0;
  int bad_cnt   = 0;

`ifdef MEM_IO_STATUS_EN
  localparam logic [7:0] STAT_EXP = 8'h03;
`else
  localparam logic [7:0] STAT_EXP = 8'h00;
`endif

  logic [7:0] ram_vec [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
  logic [7:0] rx_vec  [3] = '{8'h0A, 8'h0B, 8'h00};

  mem_io_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .r_or_w(r_or_w), .a_in(a_in), .d_in(d_in),
    .d_out(d_out), .io_buffer_full(io_buffer_full), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [7:0] data);
    r_or_w = 1'b1; a_in = addr; d_in = data;
    step;
    r_or_w = 1'b0; a_in = 32'h0; d_in = 8'h00;
  endtask

  task automatic bus_rd(input logic [31:0] addr);
    r_or_w = 1'b0; a_in = addr;
    step;
  endtask

  task automatic host_push(input logic [7:0] data);
    rx_valid = 1'b1; rx_data = data;
    step;
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; rdy = 1'b0; r_or_w = 1'b0; a_in = 32'h0; d_in = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    step; step;
    chk("rst_d_out", d_out, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rx_ready", rx_ready, 1'b1);
    chk("rst_full", io_buffer_full, 1'b0);
    rst = 1'b0; rdy = 1'b1;
    step;

    // RAM write then back-to-back reads
    for (int i = 0; i < 4; i++) bus_wr(32'h100 + i, ram_vec[i]);
    for (int i = 0; i < 4; i++) begin
      bus_rd(32'h100 + i);
      chk("ram_rd", d_out, ram_vec[i]);
    end
    a_in = 32'h0;

    // rdy low: write is ignored and d_out holds
    rdy = 1'b0;
    bus_wr(32'h100, 8'hFF);
    chk("rdy0_hold", d_out, 8'h78);
    rdy = 1'b1;
    bus_rd(32'h100);
    chk("rdy0_nowr", d_out, 8'h12);

    // TX fill with back-pressure
    for (int i = 1; i <= 9; i++) begin
      bus_wr(32'h30000, 8'h41);
      if (i == 6) chk("tx_full6", io_buffer_full, 1'b0);
      if (i == 7) chk("tx_full7", io_buffer_full, 1'b1);
    end
    chk("tx_full9", io_buffer_full, 1'b1);
    chk("tx_valid_f", tx_valid, 1'b1);
    tx_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (tx_valid) begin
        n++;
        chk("tx_byte", tx_data, 8'h41);
      end
      step;
    end
    tx_ready = 1'b0;
    chk("tx_count", n, 8);
    chk("tx_empty", tx_valid, 1'b0);
    chk("tx_full_e", io_buffer_full, 1'b0);

    // RX basic, including read of empty FIFO
    host_push(8'h0A);
    host_push(8'h0B);
    for (int i = 0; i < 3; i++) begin
      bus_rd(32'h30000);
      chk("rx_rd", d_out, rx_vec[i]);
      chk("rx_ready", rx_ready, 1'b1);
    end
    a_in = 32'h0;

    // RX full, simultaneous CPU pop and host push
    for (int i = 0; i < 8; i++) host_push(8'h80 + 8'(i));
    chk("rx_full_rdy", rx_ready, 1'b0);
    r_or_w = 1'b0; a_in = 32'h30000; rx_valid = 1'b1; rx_data = 8'hEE;
    #1;
    chk("rx_rdy_pop", rx_ready, 1'b1);
    step;
    chk("rx_pop_old", d_out, 8'h80);
    a_in = 32'h0; rx_valid = 1'b0; rx_data = 8'h00;
    #1;
    chk("rx_still_full", rx_ready, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus_rd(32'h30000);
      chk("rx_drain", d_out, (i < 7) ? (8'h81 + 8'(i)) : 8'hEE);
    end
    bus_rd(32'h30000);
    chk("rx_drain_e", d_out, 8'h00);
    a_in = 32'h0;

    // Status register with TX full and one RX byte
    for (int i = 0; i < 8; i++) bus_wr(32'h30000, 8'h20 + 8'(i));
    host_push(8'h55);
    bus_rd(32'h30004);
    chk("status", d_out, STAT_EXP);
    bus_rd(32'h30008);
    chk("io_other", d_out, 8'h00);
    bus_rd(32'h30000);
    chk("rx_55", d_out, 8'h55);
    a_in = 32'h0;
    tx_ready = 1'b1;
    chk("tx_first", tx_data, 8'h20);
    repeat (10) step;
    tx_ready = 1'b0;
    chk("tx_drained", tx_valid, 1'b0);

    // Mid-stream reset clears FIFOs but not RAM
    for (int i = 0; i < 3; i++) bus_wr(32'h30000, 8'h61 + 8'(i));
    bus_wr(32'h10, 8'h5A);
    bus_rd(32'h10);
    chk("ram_10", d_out, 8'h5A);
    chk("tx_pre_rst", tx_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_async_tx", tx_valid, 1'b0);
    chk("rst_async_d", d_out, 8'h00);
    a_in = 32'h0;
    step;
    rst = 1'b0;
    bus_rd(32'h10);
    chk("ram_after_rst", d_out, 8'h5A);
    chk("tx_after_rst", tx_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
